// File: rtl/imem_port_arb_pkg.sv
// Shared encodings for the instruction-memory port sequencer: FSM states,
// requester identity and the supported memory latency range.
package imem_port_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DEBUG = 1'b1
    } owner_e;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 7;
    localparam int LAT_CNT_W   = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; req[0] is fetch, req[1] is debug. On a tie the
// requester that did not own the previous transaction wins.
module rr_arb2
    import imem_port_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last_owner,
    output logic [1:0] gnt,
    output owner_e     owner
);

    always_comb begin
        gnt   = 2'b00;
        owner = OWN_FETCH;
        case (req)
            2'b01: begin
                gnt   = 2'b01;
                owner = OWN_FETCH;
            end
            2'b10: begin
                gnt   = 2'b10;
                owner = OWN_DEBUG;
            end
            2'b11: begin
                if (last_owner == OWN_FETCH) begin
                    gnt   = 2'b10;
                    owner = OWN_DEBUG;
                end else begin
                    gnt   = 2'b01;
                    owner = OWN_FETCH;
                end
            end
            default: begin
                gnt   = 2'b00;
                owner = OWN_FETCH;
            end
        endcase
    end

endmodule

// File: rtl/imem_port_arb.sv
// Shares one fixed-latency instruction-memory port between fetch (read-only)
// and a debug/loader master, one transaction in flight at a time.
module imem_port_arb
    import imem_port_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
        $error("imem_port_arb: MEM_LAT must be within 1..7");
    end

    localparam logic [LAT_CNT_W-1:0] CNT_LOAD = LAT_CNT_W'(MEM_LAT - 1);

    state_e                state_q, state_d;
    owner_e                last_owner_q, last_owner_d;
    owner_e                owner_q, owner_d;
    owner_e                arb_owner;
    logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic                  f_rvalid_q, f_rvalid_d;
    logic                  d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]     f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0]     d_rdata_q, d_rdata_d;
    logic [1:0]            arb_gnt;
    logic [1:0]            gnt;
    logic                  arb_en;

    rr_arb2 u_rr_arb2 (
        .req        ({d_req, f_req}),
        .last_owner (last_owner_q),
        .gnt        (arb_gnt),
        .owner      (arb_owner)
    );

    // Grants are masked while reset is held so every output reads 0 in reset.
    assign arb_en  = reset && (state_q == ST_IDLE || state_q == ST_RESP);
    assign gnt     = arb_gnt & {2{arb_en}};
    assign f_gnt   = gnt[0];
    assign d_gnt   = gnt[1];
    assign f_stall = reset & f_req & ~gnt[0];
    assign busy    = (state_q != ST_IDLE);

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        f_rvalid_d   = 1'b0;
        d_rvalid_d   = 1'b0;
        f_rdata_d    = f_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (|gnt) begin
                    owner_d      = arb_owner;
                    last_owner_d = arb_owner;
                    we_d         = gnt[1] & d_we;
                    mem_en_d     = 1'b1;
                    mem_we_d     = gnt[1] & d_we;
                    mem_addr_d   = gnt[1] ? d_addr : f_addr;
                    mem_wdata_d  = gnt[1] ? d_wdata : '0;
                    state_d      = ST_ISSUE;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (owner_q == OWN_FETCH) f_rdata_d = mem_rdata;
                        else                      d_rdata_d = mem_rdata;
                    end
                    f_rvalid_d = (owner_q == OWN_FETCH);
                    d_rvalid_d = (owner_q == OWN_DEBUG);
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_owner_q <= OWN_DEBUG;
            owner_q      <= OWN_FETCH;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            f_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            f_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            f_rvalid_q   <= f_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            f_rdata_q    <= f_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign f_rvalid  = f_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign f_rdata   = f_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_imem_port_arb.sv
// Directed bench for imem_port_arb: one instance with MEM_LAT=1, one with
// MEM_LAT=3, each backed by a small fixed-latency memory model.
module tb_imem_port_arb;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Instance 1: MEM_LAT = 1
    logic        f_req1, f_gnt1, f_rvalid1, f_stall1;
    logic [31:0] f_addr1, f_rdata1;
    logic        d_req1, d_we1, d_gnt1, d_rvalid1;
    logic [31:0] d_addr1, d_wdata1, d_rdata1;
    logic        mem_en1, mem_we1, busy1;
    logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;

    // Instance 3: MEM_LAT = 3
    logic        f_req3, f_gnt3, f_rvalid3, f_stall3;
    logic [31:0] f_addr3, f_rdata3;
    logic        d_req3, d_we3, d_gnt3, d_rvalid3;
    logic [31:0] d_addr3, d_wdata3, d_rdata3;
    logic        mem_en3, mem_we3, busy3;
    logic [31:0] mem_addr3, mem_wdata3, mem_rdata3;

    imem_port_arb #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .f_req(f_req1), .f_addr(f_addr1), .f_gnt(f_gnt1), .f_rvalid(f_rvalid1),
        .f_rdata(f_rdata1), .f_stall(f_stall1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
    );

    imem_port_arb #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .f_req(f_req3), .f_addr(f_addr3), .f_gnt(f_gnt3), .f_rvalid(f_rvalid3),
        .f_rdata(f_rdata3), .f_stall(f_stall3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
        .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
    );

    // Unwritten locations return a fixed pattern; address 0x4 holds 0x13.
    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a == 32'h4) ? 32'h0000_0013 : (32'h5A00_0000 ^ a);
    endfunction

    logic [31:0] mem1 [logic [31:0]];
    logic [31:0] mem3 [logic [31:0]];
    logic [31:0] p3a, p3b, p3c;

    always @(posedge clk) begin
        if (mem_en1) begin
            if (mem_we1) mem1[mem_addr1] = mem_wdata1;
            mem_rdata1 <= mem1.exists(mem_addr1) ? mem1[mem_addr1] : pat(mem_addr1);
        end
    end

    always @(posedge clk) begin
        if (mem_en3) begin
            if (mem_we3) mem3[mem_addr3] = mem_wdata3;
            p3a <= mem3.exists(mem_addr3) ? mem3[mem_addr3] : pat(mem_addr3);
        end
        p3b <= p3a;
        p3c <= p3b;
    end
    assign mem_rdata3 = p3c;

    always @(negedge clk) begin
        if (f_rvalid1) $display("txn dut1 fetch rdata=%h", f_rdata1);
        if (d_rvalid1) $display("txn dut1 debug rdata=%h", d_rdata1);
        if (f_rvalid3) $display("txn dut3 fetch rdata=%h", f_rdata3);
        if (d_rvalid3) $display("txn dut3 debug rdata=%h", d_rdata3);
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b0;
        f_req1 = 0; f_addr1 = '0; d_req1 = 0; d_we1 = 0; d_addr1 = '0; d_wdata1 = '0;
        f_req3 = 0; f_addr3 = '0; d_req3 = 0; d_we3 = 0; d_addr3 = '0; d_wdata3 = '0;

        // Reset held with random requests: every output must read 0.
        for (int i = 0; i < 4; i++) begin
            next();
            f_req1 = 1'($urandom); d_req1 = 1'($urandom); d_we1 = 1'($urandom);
            f_req3 = 1'($urandom); d_req3 = 1'($urandom);
            f_addr1 = $urandom; d_addr1 = $urandom; d_wdata1 = $urandom;
            #1;
            chk32("rst_ctrl1", {24'd0, f_gnt1, d_gnt1, f_stall1, f_rvalid1, d_rvalid1,
                                mem_en1, mem_we1, busy1}, 32'd0);
            chk32("rst_ctrl3", {24'd0, f_gnt3, d_gnt3, f_stall3, f_rvalid3, d_rvalid3,
                                mem_en3, mem_we3, busy3}, 32'd0);
            chk32("rst_f_rdata1", f_rdata1, 32'd0);
            chk32("rst_d_rdata1", d_rdata1, 32'd0);
            chk32("rst_mem_addr1", mem_addr1, 32'd0);
            chk32("rst_mem_wdata1", mem_wdata1, 32'd0);
        end
        next();
        reset = 1'b1;
        f_req1 = 0; d_req1 = 0; d_we1 = 0; f_req3 = 0; d_req3 = 0;
        #1;
        chk1("rel_busy1", busy1, 1'b0);
        chk1("rel_busy3", busy3, 1'b0);

        // Single fetch read, MEM_LAT=1, address 0x4 -> 0x13.
        next();
        f_req1 = 1; f_addr1 = 32'h4;
        #1;
        chk1("f1_gnt", f_gnt1, 1'b1);
        chk1("f1_stall", f_stall1, 1'b0);
        next();
        f_req1 = 0;
        #1;
        chk1("f1_mem_en", mem_en1, 1'b1);
        chk1("f1_mem_we", mem_we1, 1'b0);
        chk32("f1_mem_addr", mem_addr1, 32'h4);
        chk1("f1_busy", busy1, 1'b1);
        next(); #1;
        chk1("f1_mem_en_off", mem_en1, 1'b0);
        chk1("f1_rvalid_early", f_rvalid1, 1'b0);
        next(); #1;
        chk1("f1_rvalid", f_rvalid1, 1'b1);
        chk32("f1_rdata", f_rdata1, 32'h13);
        chk1("f1_d_rvalid", d_rvalid1, 1'b0);
        next(); #1;
        chk1("f1_rvalid_pulse", f_rvalid1, 1'b0);
        chk1("f1_idle", busy1, 1'b0);

        // Reset pulse so arbitration restarts from last_owner=DEBUG.
        next();
        reset = 1'b0;
        next();
        reset = 1'b1;

        // Both requesters held: grants alternate fetch, debug, fetch, debug.
        next();
        f_req1 = 1; f_addr1 = 32'h8; d_req1 = 1; d_we1 = 0; d_addr1 = 32'h20;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk1("alt_f_gnt", f_gnt1, 1'(k % 2 == 0));
            chk1("alt_d_gnt", d_gnt1, 1'(k % 2 == 1));
            if (k > 0) begin
                chk1("alt_f_rvalid", f_rvalid1, 1'(k % 2 == 1));
                chk1("alt_d_rvalid", d_rvalid1, 1'(k % 2 == 0));
            end
            if (k == 1 || k == 3) chk32("alt_f_rdata", f_rdata1, 32'h5A00_0008);
            if (k == 2) chk32("alt_d_rdata", d_rdata1, 32'h5A00_0020);
            for (int j = 1; j < 3; j++) begin
                next(); #1;
                chk1("alt_stall", f_stall1, 1'b1);
            end
            next();
            if (k == 3) begin
                f_req1 = 0; d_req1 = 0;
            end
            #1;
        end
        chk1("alt_last_d_rvalid", d_rvalid1, 1'b1);
        chk32("alt_last_d_rdata", d_rdata1, 32'h5A00_0020);
        chk1("alt_no_gnt", f_gnt1, 1'b0);

        // Debug write of 0xDEADBEEF to 0x10, then read it back.
        next();
        d_req1 = 1; d_we1 = 1; d_addr1 = 32'h10; d_wdata1 = 32'hDEAD_BEEF;
        #1;
        chk1("dw_gnt", d_gnt1, 1'b1);
        next();
        d_req1 = 0;
        #1;
        chk1("dw_mem_en", mem_en1, 1'b1);
        chk1("dw_mem_we", mem_we1, 1'b1);
        chk32("dw_mem_addr", mem_addr1, 32'h10);
        chk32("dw_mem_wdata", mem_wdata1, 32'hDEAD_BEEF);
        next(); next(); #1;
        chk1("dw_ack", d_rvalid1, 1'b1);
        chk32("dw_rdata_kept", d_rdata1, 32'h5A00_0020);
        next();
        d_req1 = 1; d_we1 = 0; d_addr1 = 32'h10;
        #1;
        chk1("dr_gnt", d_gnt1, 1'b1);
        next();
        d_req1 = 0;
        #1;
        chk1("dr_mem_en", mem_en1, 1'b1);
        chk1("dr_mem_we", mem_we1, 1'b0);
        chk32("dr_mem_addr", mem_addr1, 32'h10);
        next(); next(); #1;
        chk1("dr_rvalid", d_rvalid1, 1'b1);
        chk32("dr_rdata", d_rdata1, 32'hDEAD_BEEF);
        chk1("dr_f_rvalid", f_rvalid1, 1'b0);

        // MEM_LAT=3: reset in WAIT drops the transaction.
        next();
        f_req3 = 1; f_addr3 = 32'h40;
        #1;
        chk1("rw_gnt", f_gnt3, 1'b1);
        next();
        f_req3 = 0;
        #1;
        chk1("rw_mem_en", mem_en3, 1'b1);
        next(); #1;
        chk1("rw_busy_wait", busy3, 1'b1);
        reset = 1'b0;
        #1;
        chk1("rw_busy_rst", busy3, 1'b0);
        chk1("rw_mem_en_rst", mem_en3, 1'b0);
        next();
        reset = 1'b1;
        f_req3 = 1; f_addr3 = 32'h44;
        #1;
        chk1("rw_regnt", f_gnt3, 1'b1);
        chk1("rw_no_rvalid0", f_rvalid3, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            next();
            if (i == 1) f_req3 = 0;
            #1;
            chk1("rw_no_rvalid", f_rvalid3, 1'b0);
        end
        next(); #1;
        chk1("rw_rvalid", f_rvalid3, 1'b1);
        chk32("rw_rdata", f_rdata3, 32'h5A00_0044);

        // MEM_LAT=3 back-to-back fetch: one rvalid every 5 cycles.
        next();
        f_req3 = 1; f_addr3 = 32'h100;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk1("b2b_gnt", f_gnt3, 1'b1);
            if (k > 0) begin
                chk1("b2b_rvalid", f_rvalid3, 1'b1);
                chk32("b2b_rdata", f_rdata3, 32'h5A00_0100 ^ 32'(4 * (k - 1)));
            end
            for (int j = 1; j <= 4; j++) begin
                next();
                if (j == 1) begin
                    f_addr3 = 32'h100 + 32'(4 * (k + 1));
                    if (k == 3) f_req3 = 0;
                end
                #1;
                chk1("b2b_rvalid_gap", f_rvalid3, 1'b0);
                chk1("b2b_stall", f_stall3, 1'(k < 3));
            end
            next(); #1;
        end
        chk1("b2b_last_rvalid", f_rvalid3, 1'b1);
        chk32("b2b_last_rdata", f_rdata3, 32'h5A00_010C);
        chk1("b2b_last_gnt", f_gnt3, 1'b0);

        next();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_port_arb.md
Name: imem_port_arb

Overview:
Sequencer and arbiter for the single instruction-memory port. It shares the port between two requesters: the fetch stage (read-only) and a debug/loader master (read/write) used to load programs while the core runs or is held. It issues one transaction at a time to a fixed-latency synchronous memory and returns the data to the owner with a one-cycle valid pulse. It also drives a fetch stall so pc_reg can hold while fetch waits.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 1, cycles from mem_en to valid mem_rdata; legal 1..7

Ports:
clk  in  1  clock; all state changes on its rising edge
reset  in  1  asynchronous, active-low reset
f_req  in  1  fetch read request; held with f_addr until f_gnt
f_addr  in  ADDR_W  fetch address
f_gnt  out  1  fetch request accepted this cycle
f_rvalid  out  1  one-cycle pulse, f_rdata valid
f_rdata  out  DATA_W  fetch read data
f_stall  out  1  f_req & ~f_gnt
d_req  in  1  debug request; held with d_we/d_addr/d_wdata until d_gnt
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  debug address
d_wdata  in  DATA_W  debug write data
d_gnt  out  1  debug request accepted this cycle
d_rvalid  out  1  one-cycle pulse: read data valid, or write done
d_rdata  out  DATA_W  debug read data
mem_en  out  1  memory access strobe, one cycle per transaction
mem_we  out  1  memory write enable; qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data; valid MEM_LAT cycles after mem_en
busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, last_owner=DEBUG, wait counter=0. All outputs are 0, including rdata registers and mem_* outputs.
- FSM states: IDLE, ISSUE, WAIT, RESP. Only one transaction is outstanding at a time.
- Arbitration happens only in IDLE and RESP and is combinational from the req inputs.
  - If exactly one req is high, that requester is granted.
  - If both are high, the requester that is not last_owner is granted (round-robin).
  - The matching gnt is high for that single cycle.
  - On grant: latch addr, we, wdata (fetch: we=0) and the owner; update last_owner; next state=ISSUE.
  - No grant from IDLE: stay IDLE. No grant from RESP: go to IDLE.
- ISSUE, 1 cycle: mem_en=1, with mem_we/mem_addr/mem_wdata driven from the latched values. The counter is loaded with MEM_LAT-1. Next state=WAIT.
- WAIT, MEM_LAT cycles: the counter decrements each cycle.
  - On the cycle the counter is 0: capture mem_rdata into the owner's rdata register (reads only; a write leaves rdata unchanged); next state=RESP.
- RESP, 1 cycle: the owner's rvalid=1. The other rvalid stays 0.
- Latency: grant in cycle T -> mem_en in T+1 -> rvalid in T+2+MEM_LAT. Back-to-back period is MEM_LAT+2 cycles.
- Requests arriving during ISSUE or WAIT are not granted. f_stall stays high while f_req is held.
- Deasserting req before gnt is legal and has no effect. Deasserting req after gnt does not cancel the transaction.
- A write from fetch is impossible: the fetch path forces we=0.
- Reset asserted mid-transaction: the transaction is dropped, no rvalid is produced, and the FSM returns to IDLE immediately.
- Outputs mem_*, rvalid and rdata are registered. gnt and f_stall are combinational.

Decomposition:
- Shared package: FSM state encoding (IDLE/ISSUE/WAIT/RESP, 2 bits), owner encoding (OWN_FETCH=0, OWN_DEBUG=1), MEM_LAT legal range constant.
- One sub-module: rr_arb2. Two-way round-robin picker with inputs req[1:0] and last_owner, outputs gnt[1:0] and owner. Purely combinational; the last_owner register lives in imem_port_arb.

Test Plan:
- Reset: hold reset=0 with random requests -> all outputs 0 and busy=0. Release reset -> IDLE.
- Single fetch read, MEM_LAT=1, memory returns 0x00000013 for addr 0x4: f_req at T -> f_gnt at T, mem_en/mem_addr=0x4 at T+1, f_rvalid=1 with f_rdata=0x13 at T+3.
- Simultaneous f_req and d_req held continuously after reset -> grants alternate fetch, debug, fetch, debug. f_stall=1 in every fetch-waiting cycle.
- Debug write d_addr=0x10, d_wdata=0xDEADBEEF, then debug read of 0x10 -> mem_we=1 with the correct data in the ISSUE cycle; write ack d_rvalid arrives with d_rdata unchanged; the read returns 0xDEADBEEF.
- Reset pulse during WAIT (MEM_LAT=3) -> no rvalid after reset. The next request is granted in the first cycle after reset release and completes normally.
- MEM_LAT=3 back-to-back fetch reads -> rvalid exactly every 5 cycles; captured data matches the memory model per address.
